// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multi-cycle integer datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_datapath_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_MOV  = 5'h03;
  localparam logic [4:0] OP_LDW  = 5'h04;
  localparam logic [4:0] OP_STW  = 5'h05;
  localparam logic [4:0] OP_BR   = 5'h06;
  localparam logic [4:0] OP_JMP  = 5'h07;
  localparam logic [4:0] OP_JSR  = 5'h08;
  localparam logic [4:0] OP_JSRR = 5'h09;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  // Instruction field bit positions
  localparam int IR_OP_MSB   = 31;
  localparam int IR_OP_LSB   = 27;
  localparam int IR_NZP_MSB  = 26;
  localparam int IR_NZP_LSB  = 24;
  localparam int IR_IMMF     = 24;
  localparam int IR_DST_MSB  = 23;
  localparam int IR_DST_LSB  = 20;
  localparam int IR_SRC1_MSB = 19;
  localparam int IR_SRC1_LSB = 16;
  localparam int IR_SRC2_MSB = 11;
  localparam int IR_SRC2_LSB = 8;
  localparam int IR_IMM_MSB  = 15;
  localparam int IR_IMM_LSB  = 0;

  // Condition codes, ordered {p,z,n}
  localparam logic [2:0] CC_P = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_N = 3'b001;

  function automatic logic is_legal(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_JSRR);
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Integer register file: NUM_REGS x DATA_W, two async read ports, one sync write port.
// Latency: reads combinational, write visible after the clock edge.
// Backpressure: none; out-of-range indices read 0 and drop writes.
// Ports: clk, rst_n (async active-low, clears all regs), ra1/rd1, ra2/rd2, we/wa/wd.
module mc_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [3:0]        ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [3:0]        wa,
  input  logic [DATA_W-1:0] wd
);
  localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [4:0] NR = 5'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign rd1 = ({1'b0, ra1} < NR) ? regs[ra1[AW-1:0]] : '0;
  assign rd2 = ({1'b0, ra2} < NR) ? regs[ra2[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && ({1'b0, wa} < NR)) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end
endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle integer datapath with external instruction/data memories on req/ack.
// Latency (zero-wait memory): ALU/branch 4 cycles, load/store 5; each wait state adds one.
// Backpressure: FETCH and MEM hold req and address/data stable until ack; lock=0 parks in IDLE after the current instruction.
// Ports: clk, rst_n; lock; imem_req/addr/ack/rdata; dmem_req/we/addr/wdata/ack/rdata;
//        pc_out, cc_out {p,z,n}, retire pulse, halted.
// Option: MC_DATAPATH_ILLEGAL_TRAP_EN traps illegal opcodes in HALT; otherwise they retire as NOPs.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int PC_W     = 16,
  parameter int LINK_REG = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lock,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic [2:0]        cc_out,
  output logic              retire,
  output logic              halted
);
  state_t            state, state_nxt;
  logic [31:0]       ir;
  logic [PC_W-1:0]   pc, next_pc_q, next_pc, pc_plus4, rel_target;
  logic [2:0]        cc, cc_new;
  logic [DATA_W-1:0] src1_q, src2_q, res_q, maddr_q;
  logic [DATA_W-1:0] rd1, rd2, imm_dw, opb, alu_res;
  logic signed [15:0] imm_s;
  logic [4:0]        op;
  logic [3:0]        dst_idx, src1_idx, src2_idx, rf_ra2, rf_wa;
  logic              is_mem, is_link, sets_cc, rf_we;

  assign op       = ir[IR_OP_MSB:IR_OP_LSB];
  assign dst_idx  = ir[IR_DST_MSB:IR_DST_LSB];
  assign src1_idx = ir[IR_SRC1_MSB:IR_SRC1_LSB];
  assign src2_idx = ir[IR_SRC2_MSB:IR_SRC2_LSB];
  assign imm_s    = ir[IR_IMM_MSB:IR_IMM_LSB];
  // Signed size casts sign-extend or truncate to the target width.
  assign imm_dw     = DATA_W'(imm_s);
  assign pc_plus4   = pc + PC_W'(4);
  assign rel_target = pc_plus4 + (PC_W'(imm_s) << 2);
  assign opb        = ir[IR_IMMF] ? imm_dw : src2_q;

  assign is_mem  = (op == OP_LDW) || (op == OP_STW);
  assign is_link = (op == OP_JSR) || (op == OP_JSRR);
  assign sets_cc = (op == OP_ADD) || (op == OP_AND) || (op == OP_MOV) || (op == OP_LDW);

  // Port 2 reads src2 in DECODE and the store-data register in MEM; registers
  // only change in WB, so the store data stays stable across wait states.
  assign rf_ra2 = (state == MEM) ? dst_idx : src2_idx;
  assign rf_we  = (state == WB) && (sets_cc || is_link);
  assign rf_wa  = is_link ? 4'(LINK_REG) : dst_idx;

  mc_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra1(src1_idx), .rd1(rd1),
    .ra2(rf_ra2),   .rd2(rd2),
    .we(rf_we), .wa(rf_wa), .wd(res_q)
  );

  always_comb begin
    alu_res = '0;
    next_pc = pc_plus4;
    case (op)
      OP_ADD:  alu_res = src1_q + opb;
      OP_AND:  alu_res = src1_q & opb;
      OP_MOV:  alu_res = opb;
      OP_BR:   if (|(ir[IR_NZP_MSB:IR_NZP_LSB] & cc)) next_pc = rel_target;
      OP_JMP:  next_pc = PC_W'(src1_q);
      OP_JSR:  begin alu_res = DATA_W'(pc_plus4); next_pc = rel_target;    end
      OP_JSRR: begin alu_res = DATA_W'(pc_plus4); next_pc = PC_W'(src1_q); end
      default: ;
    endcase
  end

  assign cc_new = res_q[DATA_W-1] ? CC_N : ((res_q == '0) ? CC_Z : CC_P);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (lock) state_nxt = FETCH;
      FETCH:  if (imem_ack) state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = is_mem ? MEM : WB;
`ifdef MC_DATAPATH_ILLEGAL_TRAP_EN
        if (!is_legal(op)) state_nxt = HALT;
`endif
      end
      MEM:    if (dmem_ack) state_nxt = WB;
      WB:     state_nxt = lock ? FETCH : IDLE;
      HALT:   state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= '0;
      cc        <= CC_Z;
      src1_q    <= '0;
      src2_q    <= '0;
      res_q     <= '0;
      maddr_q   <= '0;
      next_pc_q <= '0;
    end else begin
      case (state)
        FETCH:  if (imem_ack) ir <= imem_rdata;
        DECODE: begin src1_q <= rd1; src2_q <= rd2; end
        EXEC: begin
          res_q     <= alu_res;
          maddr_q   <= src1_q + imm_dw;
          next_pc_q <= next_pc;
        end
        MEM:    if (dmem_ack && !dmem_we) res_q <= dmem_rdata;
        WB: begin
          pc <= next_pc_q;
          if (sets_cc) cc <= cc_new;
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = (state == MEM) && (op == OP_STW);
  assign dmem_addr  = (state == MEM) ? maddr_q : '0;
  assign dmem_wdata = (state == MEM) ? rd2 : '0;
  assign pc_out     = pc;
  assign cc_out     = cc;
  assign retire     = (state == WB);
`ifdef MC_DATAPATH_ILLEGAL_TRAP_EN
  assign halted     = (state == HALT);
`else
  assign halted     = 1'b0;
`endif
endmodule
